piece_bag_generator: RTL and testbench



---
 rtl/piece_bag_generator.sv | 142 ++++++++++++++
 tb/tb_piece_bag_generator.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/piece_bag_generator.sv
// rtl/piece_bag_generator.sv - 7-bag tetromino source with a preview FIFO
// Optional debug override of the drawn id is enabled by defining PIECE_BAG_FORCE_EN.
module piece_bag_generator #(
    parameter int          PREVIEW_DEPTH = 3,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic                       game_clk,
    input  logic                       reset_n,
    input  logic                       seed_load,
    input  logic [7:0]                 seed,
    input  logic                       piece_take,
`ifdef PIECE_BAG_FORCE_EN
    input  logic                       force_valid,
    input  logic [2:0]                 force_id,
`endif
    output logic                       piece_valid,
    output logic [2:0]                 piece_id,
    output logic [3*PREVIEW_DEPTH-1:0] preview_ids,
    output logic [PREVIEW_DEPTH-1:0]   preview_valid,
    output logic [2:0]                 bag_remaining,
    output logic [7:0]                 take_count
);
    localparam int DEPTH = PREVIEW_DEPTH + 1;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef enum logic {S_FILL, S_READY} state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [15:0]   r_lfsr;
    logic [6:0]    r_mask;
    logic [CW-1:0] r_count;
    logic [2:0]    r_fifo [DEPTH];
    logic [7:0]    r_take_count;

    logic [15:0]   w_seed_word;
    logic [15:0]   w_lfsr_next;
    logic [2:0]    w_start;
    logic [3:0]    w_scan;
    logic          w_found;
    logic [2:0]    w_lfsr_pick;
    logic [2:0]    w_sel;
    logic [6:0]    w_mask_clr;
    logic [6:0]    w_mask_next;
    logic          w_pop;
    logic          w_draw;
    logic [CW-1:0] w_count_after_pop;
    logic [CW-1:0] w_count_next;
    logic [2:0]    w_fifo_next [DEPTH];

    assign w_seed_word = {seed, ~seed};
    assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    assign w_start     = (r_lfsr[2:0] == 3'd7) ? 3'd0 : r_lfsr[2:0];

    // Scan the remaining-bag mask from the LFSR start point, wrapping mod 7.
    always_comb begin
        w_lfsr_pick = 3'd0;
        w_found     = 1'b0;
        w_scan      = 4'd0;
        for (int i = 0; i < 7; i++) begin
            w_scan = {1'b0, w_start} + 4'(i);
            if (w_scan >= 4'd7) w_scan = w_scan - 4'd7;
            if (!w_found && r_mask[w_scan[2:0]]) begin
                w_lfsr_pick = w_scan[2:0];
                w_found     = 1'b1;
            end
        end
    end

`ifdef PIECE_BAG_FORCE_EN
    assign w_sel = (force_valid && force_id != 3'd7) ? force_id : w_lfsr_pick;
`else
    assign w_sel = w_lfsr_pick;
`endif

    assign w_mask_clr  = r_mask & ~(7'b1 << w_sel);
    assign w_mask_next = (w_mask_clr == 7'h00) ? 7'h7F : w_mask_clr;

    assign w_pop             = piece_take && (r_count != '0);
    assign w_draw            = (r_state == S_FILL) || w_pop;
    assign w_count_after_pop = r_count - CW'(w_pop);
    assign w_count_next      = w_count_after_pop + CW'(w_draw);

    // Vacated slots are refilled with 0 so invalid entries always read 0.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) w_fifo_next[k] = r_fifo[k];
        if (w_pop) begin
            for (int k = 0; k < DEPTH - 1; k++) w_fifo_next[k] = r_fifo[k+1];
            w_fifo_next[DEPTH-1] = 3'd0;
        end
        for (int k = 0; k < DEPTH; k++) begin
            if (w_draw && CW'(k) == w_count_after_pop) w_fifo_next[k] = w_sel;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FILL:  if (w_count_next == CW'(DEPTH)) w_next_state = S_READY;
            S_READY: w_next_state = S_READY;
            default: w_next_state = S_FILL;
        endcase
        if (seed_load) w_next_state = S_FILL;
    end

    always_ff @(posedge game_clk) begin
        if (!reset_n) r_state <= S_FILL;
        else          r_state <= w_next_state;
    end

    always_ff @(posedge game_clk) begin
        if (!reset_n) begin
            r_lfsr       <= LFSR_SEED;
            r_mask       <= 7'h7F;
            r_count      <= '0;
            r_take_count <= 8'd0;
            for (int k = 0; k < DEPTH; k++) r_fifo[k] <= 3'd0;
        end else if (seed_load) begin
            r_lfsr       <= (w_seed_word == 16'h0000) ? 16'hACE1 : w_seed_word;
            r_mask       <= 7'h7F;
            r_count      <= '0;
            r_take_count <= 8'd0;
            for (int k = 0; k < DEPTH; k++) r_fifo[k] <= 3'd0;
        end else begin
            r_lfsr  <= w_lfsr_next;
            r_count <= w_count_next;
            for (int k = 0; k < DEPTH; k++) r_fifo[k] <= w_fifo_next[k];
            if (w_draw) r_mask <= w_mask_next;
            if (w_pop)  r_take_count <= r_take_count + 8'd1;
        end
    end

    assign piece_valid   = (r_count != '0);
    assign piece_id      = r_fifo[0];
    assign bag_remaining = 3'($countones(r_mask));
    assign take_count    = r_take_count;

    for (genvar k = 0; k < PREVIEW_DEPTH; k++) begin : g_preview
        assign preview_ids[3*k +: 3] = r_fifo[k+1];
        assign preview_valid[k]      = (r_count > CW'(k + 1));
    end
endmodule

// File: tb/tb_piece_bag_generator.sv
// tb/tb_piece_bag_generator.sv - scoreboard bench for piece_bag_generator
module tb_piece_bag_generator;
    localparam int PD    = 3;
    localparam int DEPTH = PD + 1;

    logic          game_clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          seed_load = 1'b0;
    logic [7:0]    seed = 8'd0;
    logic          piece_take = 1'b0;
    logic          f_valid = 1'b0;
    logic [2:0]    f_id = 3'd0;
    logic          piece_valid;
    logic [2:0]    piece_id;
    logic [3*PD-1:0] preview_ids;
    logic [PD-1:0] preview_valid;
    logic [2:0]    bag_remaining;
    logic [7:0]    take_count;

    piece_bag_generator #(.PREVIEW_DEPTH(PD), .LFSR_SEED(16'hACE1)) dut (
        .game_clk(game_clk), .reset_n(reset_n), .seed_load(seed_load), .seed(seed),
        .piece_take(piece_take),
`ifdef PIECE_BAG_FORCE_EN
        .force_valid(f_valid), .force_id(f_id),
`endif
        .piece_valid(piece_valid), .piece_id(piece_id), .preview_ids(preview_ids),
        .preview_valid(preview_valid), .bag_remaining(bag_remaining), .take_count(take_count)
    );

    always #5 game_clk = ~game_clk;

    int checks = 0;
    int failures = 0;

    logic [2:0]  q[$];
    logic [2:0]  pushed[$];
    logic [15:0] m_lfsr;
    logic [6:0]  m_mask;
    logic [7:0]  m_tc;
    logic        sb_pop;
    logic [2:0]  sb_exp;
    logic [2:0]  sb_act;

    function automatic logic [2:0] model_pick(input logic [15:0] l, input logic [6:0] m);
        int c;
        c = int'(l[2:0]);
        if (c == 7) c = 0;
        for (int i = 0; i < 7; i++) begin
            int idx;
            idx = (c + i) % 7;
            if (m[idx]) return 3'(idx);
        end
        return 3'd0;
    endfunction

    function automatic logic [3*PD-1:0] exp_preview();
        logic [3*PD-1:0] r;
        r = '0;
        for (int k = 0; k < PD; k++) if (q.size() > k + 1) r[3*k +: 3] = q[k+1];
        return r;
    endfunction

    function automatic logic [PD-1:0] exp_pvalid();
        logic [PD-1:0] r;
        r = '0;
        for (int k = 0; k < PD; k++) r[k] = (q.size() > k + 1);
        return r;
    endfunction

    task automatic model_reset();
        q.delete();
        pushed.delete();
        m_lfsr = 16'hACE1;
        m_mask = 7'h7F;
        m_tc   = 8'd0;
    endtask

    task automatic do_reset(input logic take);
        reset_n    = 1'b0;
        piece_take = take;
        @(posedge game_clk);
        @(posedge game_clk);
        @(negedge game_clk);
        reset_n    = 1'b1;
        piece_take = 1'b0;
        model_reset();
    endtask

    // Drives one cycle; the model pushes expected ids on draws and pops them on accepted takes.
    task automatic step(input logic take, input logic sl, input logic [7:0] sd);
        piece_take = take;
        seed_load  = sl;
        seed       = sd;
        sb_pop = 1'b0;
        sb_exp = 3'd0;
        sb_act = piece_id;
        if (sl) begin
            logic [15:0] w;
            w = {sd, ~sd};
            m_lfsr = (w == 16'h0000) ? 16'hACE1 : w;
            m_mask = 7'h7F;
            m_tc   = 8'd0;
            q.delete();
            pushed.delete();
        end else begin
            if (take && q.size() != 0) begin
                sb_pop = 1'b1;
                sb_exp = q.pop_front();
                m_tc++;
            end
            if (q.size() < DEPTH) begin
                logic [2:0] id;
                id = model_pick(m_lfsr, m_mask);
`ifdef PIECE_BAG_FORCE_EN
                if (f_valid && f_id != 3'd7) id = f_id;
`endif
                m_mask = m_mask & ~(7'b1 << id);
                if (m_mask == 7'h00) m_mask = 7'h7F;
                q.push_back(id);
                pushed.push_back(id);
            end
            m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
        end
        @(posedge game_clk);
        @(negedge game_clk);
        piece_take = 1'b0;
        seed_load  = 1'b0;
    endtask

    task automatic test_reset();
        logic [2:0] exp_head;
        do_reset(1'b0);
        checks++; if (piece_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b expected 0", piece_valid); end
        checks++; if (piece_id !== 3'd0) begin failures++; $display("FAIL reset_id: got %0d expected 0", piece_id); end
        checks++; if (preview_valid !== '0) begin failures++; $display("FAIL reset_pvalid: got %b expected 0", preview_valid); end
        checks++; if (preview_ids !== '0) begin failures++; $display("FAIL reset_pids: got %h expected 0", preview_ids); end
        checks++; if (bag_remaining !== 3'd7) begin failures++; $display("FAIL reset_bag: got %0d expected 7", bag_remaining); end
        checks++; if (take_count !== 8'd0) begin failures++; $display("FAIL reset_tc: got %0d expected 0", take_count); end
        for (int c = 1; c <= DEPTH; c++) begin
            step(1'b0, 1'b0, 8'd0);
            exp_head = q[0];
            checks++; if (piece_valid !== 1'b1) begin failures++; $display("FAIL fill_valid c%0d: got %0b expected 1", c, piece_valid); end
            checks++; if (piece_id !== exp_head) begin failures++; $display("FAIL fill_id c%0d: got %0d expected %0d", c, piece_id, exp_head); end
            checks++; if (preview_valid !== exp_pvalid()) begin failures++; $display("FAIL fill_pvalid c%0d: got %b expected %b", c, preview_valid, exp_pvalid()); end
        end
        checks++; if (preview_valid !== 3'b111) begin failures++; $display("FAIL full_pvalid: got %b expected 111", preview_valid); end
        for (int c = 0; c < 5; c++) begin
            step(1'b0, 1'b0, 8'd0);
            exp_head = q[0];
            checks++; if (piece_id !== exp_head || preview_ids !== exp_preview()) begin
                failures++; $display("FAIL hold_ids: got %0d/%h expected %0d/%h", piece_id, preview_ids, exp_head, exp_preview()); end
            checks++; if (bag_remaining !== 3'($countones(m_mask))) begin failures++; $display("FAIL hold_bag: got %0d expected %0d", bag_remaining, $countones(m_mask)); end
            checks++; if (dut.r_lfsr !== m_lfsr) begin failures++; $display("FAIL hold_lfsr: got %h expected %h", dut.r_lfsr, m_lfsr); end
        end
    endtask

    task automatic test_bag();
        logic [6:0] seen;
        for (int t = 0; t < 14; t++) begin
            step(1'b1, 1'b0, 8'd0);
            checks++; if (sb_pop !== 1'b1) begin failures++; $display("FAIL bag_pop t%0d: got 0 expected 1", t); end
            checks++; if (sb_act !== sb_exp || sb_act === 3'd7) begin failures++; $display("FAIL bag_id t%0d: got %0d expected %0d", t, sb_act, sb_exp); end
        end
        checks++; if (take_count !== 8'd14) begin failures++; $display("FAIL bag_tc: got %0d expected 14", take_count); end
        for (int g = 0; g < 2; g++) begin
            seen = '0;
            for (int j = 0; j < 7; j++) seen = seen | (7'b1 << pushed[7*g + j]);
            checks++; if (seen !== 7'h7F) begin failures++; $display("FAIL bag_perm g%0d: got %h expected 7f", g, seen); end
        end
    endtask

    task automatic test_seed_repeat();
        logic [2:0] seq [20];
        int n;
        for (int run = 0; run < 2; run++) begin
            step(1'b0, 1'b1, 8'h5A);
            checks++; if (take_count !== 8'd0) begin failures++; $display("FAIL seed_tc r%0d: got %0d expected 0", run, take_count); end
            checks++; if (piece_valid !== 1'b0) begin failures++; $display("FAIL seed_valid r%0d: got %0b expected 0", run, piece_valid); end
            n = 0;
            for (int t = 0; t < 60 && n < 20; t++) begin
                step(1'b1, 1'b0, 8'd0);
                if (sb_pop) begin
                    checks++; if (sb_act !== sb_exp) begin failures++; $display("FAIL seed_id r%0d n%0d: got %0d expected %0d", run, n, sb_act, sb_exp); end
                    if (run == 0) seq[n] = sb_exp;
                    else begin
                        checks++; if (sb_act !== seq[n]) begin failures++; $display("FAIL seed_repeat n%0d: got %0d expected %0d", n, sb_act, seq[n]); end
                    end
                    n++;
                end
            end
            checks++; if (n != 20) begin failures++; $display("FAIL seed_takes r%0d: got %0d expected 20", run, n); end
        end
    endtask

    task automatic test_seed_take();
        for (int t = 0; t < DEPTH; t++) step(1'b0, 1'b0, 8'd0);
        checks++; if (preview_valid !== 3'b111) begin failures++; $display("FAIL st_full: got %b expected 111", preview_valid); end
        step(1'b1, 1'b1, 8'h33);
        checks++; if (take_count !== 8'd0) begin failures++; $display("FAIL st_tc: got %0d expected 0", take_count); end
        checks++; if (piece_valid !== 1'b0 || piece_id !== 3'd0) begin failures++; $display("FAIL st_flush: got %0b/%0d expected 0/0", piece_valid, piece_id); end
        for (int c = 1; c <= DEPTH; c++) begin
            step(1'b0, 1'b0, 8'd0);
            checks++; if (piece_valid !== 1'b1 || piece_id !== q[0]) begin failures++; $display("FAIL st_refill c%0d: got %0b/%0d expected 1/%0d", c, piece_valid, piece_id, q[0]); end
            checks++; if (preview_valid !== exp_pvalid()) begin failures++; $display("FAIL st_pvalid c%0d: got %b expected %b", c, preview_valid, exp_pvalid()); end
        end
        checks++; if (preview_ids !== exp_preview()) begin failures++; $display("FAIL st_pids: got %h expected %h", preview_ids, exp_preview()); end
    endtask

    task automatic test_seed_zero();
        step(1'b0, 1'b1, 8'h00);
        checks++; if (dut.r_lfsr !== 16'h00FF) begin failures++; $display("FAIL zero_seed: got %h expected 00ff", dut.r_lfsr); end
        force dut.w_seed_word = 16'h0000;
        step(1'b0, 1'b1, 8'hA5);
        release dut.w_seed_word;
        m_lfsr = 16'hACE1;
        checks++; if (dut.r_lfsr !== 16'hACE1) begin failures++; $display("FAIL zero_word: got %h expected ace1", dut.r_lfsr); end
        for (int t = 0; t < 10; t++) begin
            step(1'b1, 1'b0, 8'd0);
            if (sb_pop) begin
                checks++; if (sb_act !== sb_exp) begin failures++; $display("FAIL zero_id t%0d: got %0d expected %0d", t, sb_act, sb_exp); end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int t = 0; t < 3; t++) step(1'b1, 1'b0, 8'd0);
        do_reset(1'b1);
        checks++; if (take_count !== 8'd0 || piece_valid !== 1'b0) begin failures++; $display("FAIL mid_reset: got %0d/%0b expected 0/0", take_count, piece_valid); end
        checks++; if (bag_remaining !== 3'd7) begin failures++; $display("FAIL mid_bag: got %0d expected 7", bag_remaining); end
        step(1'b1, 1'b0, 8'd0);
        checks++; if (piece_valid !== 1'b1 || piece_id !== q[0]) begin failures++; $display("FAIL mid_first: got %0b/%0d expected 1/%0d", piece_valid, piece_id, q[0]); end
        checks++; if (take_count !== 8'd0) begin failures++; $display("FAIL mid_tc: got %0d expected 0", take_count); end
    endtask

`ifdef PIECE_BAG_FORCE_EN
    task automatic test_force();
        do_reset(1'b0);
        f_valid = 1'b1;
        f_id    = 3'd3;
        step(1'b0, 1'b0, 8'd0);
        checks++; if (bag_remaining !== 3'd6) begin failures++; $display("FAIL force_bag1: got %0d expected 6", bag_remaining); end
        for (int t = 1; t < DEPTH; t++) step(1'b0, 1'b0, 8'd0);
        checks++; if (piece_id !== 3'd3 || preview_ids !== 9'b011_011_011) begin failures++; $display("FAIL force_ids: got %0d/%h expected 3/0db", piece_id, preview_ids); end
        checks++; if (bag_remaining !== 3'd6) begin failures++; $display("FAIL force_bag: got %0d expected 6", bag_remaining); end
        f_valid = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_bag();
        test_seed_repeat();
        test_seed_take();
        test_seed_zero();
        test_reset_mid();
`ifdef PIECE_BAG_FORCE_EN
        test_force();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
